// File: rtl/ethernet_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_tx_scheduler
// Brief    : Round-robin scheduler sharing one TX frame engine among N_REQ
//            requesters, with start timeout and post-frame holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int START_TIMEOUT  = 64,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                i_main_clk,
    input  logic                i_rst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [16*N_REQ-1:0] i_req_payload_size,
    input  logic [N_REQ-1:0]    i_req_use_lfsr,
    output logic [N_REQ-1:0]    o_grant,
    output logic [N_REQ-1:0]    o_done,
    output logic                o_error,
    output logic                o_tx_start,
    output logic [15:0]         o_tx_payload_size,
    output logic                o_tx_use_lfsr,
    input  logic                i_tx_fsm_busy,
    output logic                o_busy,
    output logic [15:0]         o_frame_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(START_TIMEOUT + HOLDOFF_CYCLES + 2);

    localparam logic [IW-1:0]    c_last_idx     = IW'(N_REQ - 1);
    localparam logic [IW:0]      c_n_req        = (IW+1)'(N_REQ);
    localparam logic [TW-1:0]    c_timeout_last = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0]    c_holdoff_last = TW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [15:0]      c_max_payload  = 16'(MAX_PAYLOAD);
    localparam logic [N_REQ-1:0] c_one          = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_HOLDOFF   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_win_idx;
    logic [TW-1:0]   r_timer;
    logic [IW-1:0]   w_win_idx;
    logic [15:0]     w_req_size;
    logic            w_accept;
    logic            w_timeout;
    logic            w_holdoff_done;

    // Scan downward so the candidate closest after rr_ptr is written last and wins.
    always_comb begin
        logic [IW:0] w_cand;
        w_cand    = '0;
        w_win_idx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_cand = {1'b0, r_rr_ptr} + (IW+1)'(off);
            if (w_cand >= c_n_req) begin
                w_cand = w_cand - c_n_req;
            end
            if (i_req[w_cand[IW-1:0]]) begin
                w_win_idx = w_cand[IW-1:0];
            end
        end
    end

    assign w_req_size     = i_req_payload_size[16*w_win_idx +: 16];
    assign w_accept       = (r_state == S_IDLE) && (|i_req) && !i_tx_fsm_busy;
    assign w_timeout      = (r_timer == c_timeout_last);
    assign w_holdoff_done = (HOLDOFF_CYCLES == 0) || (r_timer == c_holdoff_last);
    assign o_busy         = (r_state != S_IDLE);

    always_ff @(posedge i_main_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Busy is only meaningful once the start strobe is actually on the wire.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_START;
            end
            S_START: begin
                if (o_tx_start) begin
                    if (i_tx_fsm_busy)  w_next_state = S_WAIT_DONE;
                    else if (w_timeout) w_next_state = S_HOLDOFF;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_fsm_busy) w_next_state = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (w_holdoff_done) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_main_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_grant           <= '0;
            o_done            <= '0;
            o_error           <= 1'b0;
            o_tx_start        <= 1'b0;
            o_tx_payload_size <= '0;
            o_tx_use_lfsr     <= 1'b0;
            o_frame_count     <= '0;
            r_rr_ptr          <= c_last_idx;
            r_win_idx         <= '0;
            r_timer           <= '0;
        end else begin
            o_grant <= '0;
            o_done  <= '0;
            o_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_grant           <= c_one << w_win_idx;
                        r_win_idx         <= w_win_idx;
                        r_rr_ptr          <= w_win_idx;
                        o_tx_payload_size <= (w_req_size > c_max_payload) ? c_max_payload : w_req_size;
                        o_tx_use_lfsr     <= i_req_use_lfsr[w_win_idx];
                        r_timer           <= '0;
                    end
                end
                S_START: begin
                    if (!o_tx_start) begin
                        o_tx_start <= 1'b1;
                        r_timer    <= '0;
                    end else if (i_tx_fsm_busy) begin
                        o_tx_start <= 1'b0;
                        r_timer    <= '0;
                    end else if (w_timeout) begin
                        o_tx_start <= 1'b0;
                        o_error    <= 1'b1;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_fsm_busy) begin
                        o_done        <= c_one << r_win_idx;
                        o_frame_count <= o_frame_count + 16'd1;
                        r_timer       <= '0;
                    end
                end
                S_HOLDOFF: begin
                    r_timer <= w_holdoff_done ? '0 : r_timer + TW'(1);
                end
                default: r_timer <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire
